// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem request, out slot plus one-entry skid, redirect drop.
// Optional misaligned-fetch trap when IF_ALIGN_CHECK_EN is defined.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic        inst_valid,
    output logic        fetch_err
);

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_inflight;
    logic        skid_vld;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc4;
    logic        err_q;

    logic consumed;
    logic out_free;
    logic req_room;
    logic misaligned;
    logic outstanding;

    assign consumed = inst_valid && !stop && !redirect;
    assign out_free = !inst_valid || consumed;
    // Request gating looks only at stop and slot occupancy, never at the response.
    assign req_room = !skid_vld && (!inst_valid || !stop);

`ifdef IF_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req    = (state == S_REQ) && req_room && !misaligned;
    assign imem_addr   = pc;
    assign outstanding = (((state == S_WAIT) || (state == S_DROP)) && !imem_rvalid)
                         || (imem_req && imem_ready);
    assign fetch_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pc_inflight <= '0;
            skid_vld    <= 1'b0;
            skid_inst   <= '0;
            skid_pc     <= '0;
            skid_pc4    <= '0;
            inst_out    <= NOP_INST;
            pc_out      <= '0;
            pc4_out     <= '0;
            inst_valid  <= 1'b0;
            err_q       <= 1'b0;
        end else if (redirect) begin
`ifdef IF_ALIGN_CHECK_EN
            pc <= redirect_pc;
`else
            pc <= redirect_pc & ~32'h3;
`endif
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            err_q      <= 1'b0;
            skid_vld   <= 1'b0;
            state      <= outstanding ? S_DROP : S_REQ;
        end else begin
            if (consumed) begin
                if (skid_vld) begin
                    inst_out <= skid_inst;
                    pc_out   <= skid_pc;
                    pc4_out  <= skid_pc4;
                    skid_vld <= 1'b0;
                end else begin
                    inst_valid <= 1'b0;
                    inst_out   <= NOP_INST;
                end
                err_q <= 1'b0;
            end

            case (state)
                S_REQ: begin
`ifdef IF_ALIGN_CHECK_EN
                    if (misaligned && out_free && !skid_vld) begin
                        inst_out   <= NOP_INST;
                        pc_out     <= pc;
                        pc4_out    <= pc + 32'd4;
                        inst_valid <= 1'b1;
                        err_q      <= 1'b1;
                        state      <= S_ERR;
                    end
`endif
                    if (imem_req && imem_ready) begin
                        pc_inflight <= pc;
                        pc          <= pc + 32'd4;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // Skid is always empty here: a request is only issued with skid empty.
                        if (out_free) begin
                            inst_out   <= imem_rdata;
                            pc_out     <= pc_inflight;
                            pc4_out    <= pc_inflight + 32'd4;
                            inst_valid <= 1'b1;
                        end else begin
                            skid_inst <= imem_rdata;
                            skid_pc   <= pc_inflight;
                            skid_pc4  <= pc_inflight + 32'd4;
                            skid_vld  <= 1'b1;
                        end
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: begin
`ifdef IF_ALIGN_CHECK_EN
                    state <= S_ERR;
`else
                    state <= S_REQ;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Random stall/redirect/reset traffic against a fetch-stream reference model of if_fetch.
module tb_if_fetch;
    localparam logic [31:0] RST_PC = 32'h1C00_0000;
    localparam logic [31:0] NOP    = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        inst_valid;
    logic        fetch_err;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst(rst), .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .pc_out(pc_out), .pc4_out(pc4_out), .inst_valid(inst_valid), .fetch_err(fetch_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: next request address, next expected presented PC, memory state.
    logic [31:0] req_pc, exp_pc, mem_addr, last_addr;
    bit          mem_busy, drop_pend, prev_stall_req;
    int          mem_wait;
    bit          chk_reset, chk_redir, chk_redir_req, chk_valid;
    int          n_consumed = 0;

    task automatic one_cycle(input bit do_reset, input bit s, input bit r,
                             input logic [31:0] rpc, input bit rdy, input int lat);
        bit          rvalid_now, req, consumed, acc;
        logic [31:0] tgt;
        @(negedge clk);
        rst         = !do_reset;
        stop        = s;
        redirect    = r;
        redirect_pc = rpc;
        rvalid_now  = mem_busy && (mem_wait == 0);
        imem_rvalid = rvalid_now;
        imem_rdata  = rvalid_now ? mem_word(mem_addr) : $urandom;
        #1;
        req        = imem_req;
        imem_ready = rdy;
        #1;
        if (chk_reset) begin
            check("rst_valid", inst_valid, 0);
            check("rst_inst", inst_out, NOP);
            check("rst_pc", pc_out, 0);
            check("rst_pc4", pc4_out, 0);
            check("rst_err", fetch_err, 0);
            check("rst_req", imem_req, 1);
        end
        if (chk_redir) check("redir_clear", inst_valid, 0);
        if (chk_redir_req) check("redir_req", imem_req, 1);
        if (chk_valid) check("resp_latency", inst_valid, 1);
        if (!inst_valid) check("nop_when_idle", inst_out, NOP);
        if (mem_busy) check("one_outstanding", imem_req, 0);
        if (req) check("imem_addr", imem_addr, req_pc);
        if (prev_stall_req && req) check("addr_stable", imem_addr, last_addr);
        consumed = !do_reset && inst_valid && !s && !r;
        if (consumed) begin
            check("stream_pc", pc_out, exp_pc);
            check("stream_inst", inst_out, mem_word(exp_pc));
            check("stream_pc4", pc4_out, exp_pc + 32'd4);
        end

        acc = req && rdy;
        chk_reset = 0; chk_redir = 0; chk_redir_req = 0; chk_valid = 0;
        if (do_reset) begin
            req_pc = RST_PC; exp_pc = RST_PC;
            mem_busy = 0; drop_pend = 0; prev_stall_req = 0;
            chk_reset = 1;
        end else begin
            if (consumed) begin
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (rvalid_now) mem_busy = 0;
            else if (mem_busy) mem_wait--;
            if (acc) begin
                mem_busy = 1; mem_wait = lat - 1; mem_addr = imem_addr;
            end
            if (r) begin
`ifdef IF_ALIGN_CHECK_EN
                tgt = rpc;
`else
                tgt = rpc & ~32'h3;
`endif
                drop_pend = mem_busy;
                req_pc = tgt; exp_pc = tgt;
                chk_redir = 1;
                chk_redir_req = !mem_busy;
                prev_stall_req = 0;
            end else begin
                if (rvalid_now && !drop_pend && (!inst_valid || consumed)) chk_valid = 1;
                if (rvalid_now) drop_pend = 0;
                if (acc) req_pc = req_pc + 32'd4;
                prev_stall_req = req && !rdy;
                last_addr = imem_addr;
            end
        end
    endtask

    int          stop_len = 0;
    bit          s_r, r_r, do_rst;
    logic [31:0] tgt_r;

    initial begin
        rst = 1'b0; stop = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        req_pc = RST_PC; exp_pc = RST_PC; mem_addr = '0; last_addr = '0;
        mem_busy = 0; drop_pend = 0; prev_stall_req = 0; mem_wait = 0;
        chk_reset = 1; chk_redir = 0; chk_redir_req = 0; chk_valid = 0;

        // Free run with 1-cycle memory, then a stall while out is full.
        repeat (8) one_cycle(0, 0, 0, '0, 1, 1);
        repeat (5) one_cycle(0, 1, 0, '0, 1, 1);
        repeat (6) one_cycle(0, 0, 0, '0, 1, 1);
        // Redirect while waiting on a slow response, then redirect+stop+rvalid together.
        one_cycle(0, 0, 0, '0, 1, 3);
        one_cycle(0, 0, 1, 32'h1C00_0100, 1, 1);
        repeat (4) one_cycle(0, 0, 0, '0, 1, 1);
        one_cycle(0, 1, 0, '0, 1, 1);
        one_cycle(0, 1, 0, '0, 1, 1);
        one_cycle(0, 1, 1, 32'h1C00_0200, 1, 1);
        repeat (4) one_cycle(0, 0, 0, '0, 1, 1);

        for (int i = 0; i < 4000; i++) begin
            do_rst = ($urandom_range(0, 299) == 0);
            if (stop_len > 0) begin
                s_r = 1; stop_len--;
            end else begin
                s_r = 0;
                if ($urandom_range(0, 7) == 0) stop_len = $urandom_range(1, 6);
            end
            r_r = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) tgt_r = 32'hFFFF_FFF8;
            else tgt_r = RST_PC + ($urandom_range(0, 255) << 2);
`ifndef IF_ALIGN_CHECK_EN
            tgt_r[1:0] = 2'($urandom_range(0, 3));
`endif
            one_cycle(do_rst, s_r, r_r, tgt_r, ($urandom_range(0, 2) != 0), $urandom_range(1, 3));
        end
        check("consumed_enough", 32'(n_consumed > 500), 1);

        one_cycle(1, 0, 0, '0, 0, 1);
        repeat (2) one_cycle(0, 0, 0, '0, 0, 1);
`ifdef IF_ALIGN_CHECK_EN
        @(negedge clk);
        redirect = 1; redirect_pc = 32'h1C00_0102; stop = 0; imem_ready = 0; imem_rvalid = 0;
        @(negedge clk);
        redirect = 0;
        #2 check("mis_req0", imem_req, 0);
        @(negedge clk);
        #2;
        check("mis_err", fetch_err, 1);
        check("mis_valid", inst_valid, 1);
        check("mis_inst", inst_out, NOP);
        check("mis_pc", pc_out, 32'h1C00_0102);
        check("mis_pc4", pc4_out, 32'h1C00_0106);
        check("mis_req1", imem_req, 0);
        stop = 0;
        @(negedge clk);
        #2;
        check("mis_err_clr", fetch_err, 0);
        check("mis_req2", imem_req, 0);
`else
        one_cycle(0, 0, 1, 32'h1C00_0102, 0, 1);
        one_cycle(0, 0, 0, '0, 1, 1);
        check("mis_fetch_addr", imem_addr, 32'h1C00_0100);
        repeat (3) one_cycle(0, 0, 0, '0, 1, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the miniLA pipeline. Holds the architectural fetch PC and issues one request at a time to the instruction memory port. It presents each returned instruction with its PC and PC+4 to the IF/ID pipeline register. It absorbs hazard-unit stalls with a one-entry skid slot and discards in-flight responses after a branch/jump redirect.

## Interface
- `RESET_PC`, default 32'h1C00_0000: fetch address after reset.
- `NOP_INST`, default 32'h0340_0000: instruction word driven when no valid instruction is presented (`andi r0,r0,0`).

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `stop`, in, 1: stall from the hazard unit. It is the same signal that holds IF/ID.
- `redirect`, in, 1: taken branch/jump from a later stage.
- `redirect_pc`, in, 32: target address for `redirect`.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address, valid while `imem_req`=1.
- `imem_ready`, in, 1: request accepted this cycle.
- `imem_rvalid`, in, 1: response valid. Arrives 1 or more cycles after acceptance.
- `imem_rdata`, in, 32: response instruction word.
- `inst_out`, out, 32: presented instruction; `NOP_INST` when `inst_valid`=0.
- `pc_out`, out, 32: PC of the presented instruction.
- `pc4_out`, out, 32: `pc_out`+4, modulo 2^32.
- `inst_valid`, out, 1: output slot holds a real instruction.
- `fetch_err`, out, 1: misaligned-fetch marker; see Configuration.

## Operation
- **Consumption.** The output slot is consumed at an edge where `inst_valid`=1, `stop`=0 and `redirect`=0.
- **FSM states:**
  - `S_REQ`: `imem_req` = (skid empty) && (out empty || consumed this cycle); `imem_addr`=pc. On `imem_ready`: latch `pc_inflight`=pc, pc<=pc+4, go to `S_WAIT`.
  - `S_WAIT`: wait for `imem_rvalid`.
    - If the out slot is empty or consumed this edge, the response goes to the out slot.
    - Otherwise it goes to the skid slot.
    - The slot is loaded with inst=`imem_rdata`, pc=`pc_inflight`, pc4=`pc_inflight`+4. Then go to `S_REQ`.
  - `S_DROP`: wait for `imem_rvalid`, discard the data, go to `S_REQ`.
  - `S_ERR`: only with the macro; see Configuration.
- **Skid slot.** When the out slot is consumed and the skid slot is full, the skid contents move to the out slot on the same edge.
- **Redirect.** Highest priority after reset; overrides `stop`. At the redirect edge:
  - pc<=`redirect_pc`.
  - Out and skid slots are invalidated.
  - The state goes to `S_DROP` if a request is outstanding: state `S_WAIT` without `imem_rvalid` this cycle, or `imem_ready`=1 this cycle. Otherwise it goes to `S_REQ`.
  - A redirect while in `S_DROP` only updates pc.
  - A redirect in the same cycle as `imem_rvalid` discards that response.
- **Reset values** (`rst`=0 at an edge):
  - pc=`RESET_PC`, state=`S_REQ`, both slots empty.
  - `inst_out`=`NOP_INST`, `pc_out`=0, `pc4_out`=0, `inst_valid`=0, `fetch_err`=0.
  - Reset aborts any outstanding request. Instruction memory shares `rst`, so no post-reset `imem_rvalid` arrives for a pre-reset request.
- **Outputs** are driven directly from the out-slot registers; there is no combinational path from `imem_rdata` to them.

## Timing
- Only one request is outstanding at any time.
- Minimum latency: `imem_req` is high in cycle C with `imem_ready`=1 and `imem_rvalid` arrives in C+1. Then `inst_valid`=1 after the C+1 edge.
- Peak throughput is 1 instruction every 2 cycles with 1-cycle memory.
- After a redirect edge with no outstanding request, `imem_req`=1 with `imem_addr`=`redirect_pc` in the next cycle.
- `imem_req` depends combinationally on `stop` and on the slot state only; it never depends on `imem_rvalid`.
- `imem_addr` must stay stable while `imem_req`=1 and `imem_ready`=0, unless `redirect` occurs.

## Configuration
- **`IF_ALIGN_CHECK_EN` defined:**
  - If pc[1:0]≠0 while in `S_REQ`, no request is issued.
  - When the out slot is free, it is loaded with `NOP_INST`, pc_out=pc, pc4_out=pc+4, `inst_valid`=1, `fetch_err`=1. The state goes to `S_ERR`.
  - `S_ERR` issues no requests and holds until `redirect` or reset.
  - `fetch_err` follows the out slot: it clears when that slot is consumed, redirected or reset.
- **`IF_ALIGN_CHECK_EN` undefined:**
  - pc is loaded with `{redirect_pc[31:2],2'b00}`.
  - `fetch_err` is tied to 0.
  - `S_ERR` does not exist.

## Test plan
- **Reset then free run, 1-cycle memory, `stop`=0:** first `imem_addr`=32'h1C00_0000. Outputs show pc 1C00_0000, 1C00_0004, 1C00_0008, each `inst_valid` one edge after its `imem_rvalid`, pc4 = pc+4.
- **Stall absorb:** `stop`=1 for 5 cycles while out holds pc 1C00_0004. The next response goes to skid and `imem_req` stays 0. On `stop`=0, 1C00_0004 is consumed and then 1C00_0008 appears from skid next cycle. No instruction is lost or duplicated.
- **Redirect with outstanding request:** `redirect`=1, `redirect_pc`=32'h1C00_0100 while in `S_WAIT`. The late `imem_rvalid` (data 32'hDEAD_BEEF) is never presented. The next request address is 1C00_0100.
- **Redirect plus `stop` plus `imem_rvalid` in the same cycle:** both slots are cleared, `inst_valid`=0 and `inst_out`=32'h0340_0000 next cycle.
- **Mid-run reset:** `rst`=0 for 1 cycle while the skid slot is full. All outputs return to reset values and fetch restarts at 1C00_0000.
- **With `IF_ALIGN_CHECK_EN`:** redirect to 32'h1C00_0102 gives `fetch_err`=1, `inst_out`=32'h0340_0000, `pc_out`=1C00_0102 and no `imem_req` until the next redirect. Without the macro, the same redirect fetches 1C00_0100.
